smoldvi_link_sequencer: RTL and testbench

Pixel-clock-domain controller that sequences DVI link bring-up and shutdown. Gates the pixel-clock driver, holds TMDS lanes and the timing generator in reset until the output clock has run for a settle period, and shuts down only on a frame boundary so sinks never see a truncated frame. Sits between the top-level enable/PLL status and the clock driver, TMDS lanes and timing generator.

---
 rtl/smoldvi_pkg.sv | 60 ++++++
 rtl/smoldvi_hpd_debounce.sv | 42 ++++
 rtl/smoldvi_link_sequencer.sv | 165 ++++++++++++++++
 tb/tb_smoldvi_link_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/smoldvi_pkg.sv
// smoldvi_pkg
//   Shared definitions for the smoldvi link controller. Debug tooling decodes
//   the sequencer's `state` output against smoldvi_link_state_e.
//   Contents:
//     smoldvi_link_state_e   - link sequencer state encodings
//     smoldvi_link_outs_t    - registered control outputs, one bit each
//     smoldvi_link_decode()  - state -> control outputs
//     smoldvi_cnt_width()    - down-counter width for the larger of two spans
package smoldvi_pkg;

  typedef enum logic [2:0] {
    SMOLDVI_LINK_OFF        = 3'd0,
    SMOLDVI_LINK_WAIT_LOCK  = 3'd1,
    SMOLDVI_LINK_CLK_SETTLE = 3'd2,
    SMOLDVI_LINK_RUN        = 3'd3,
    SMOLDVI_LINK_DRAIN      = 3'd4,
    SMOLDVI_LINK_CLK_HOLD   = 3'd5
  } smoldvi_link_state_e;

  typedef struct packed {
    logic clk_out_en;
    logic lane_rst;
    logic timing_rst;
    logic link_up;
  } smoldvi_link_outs_t;

  function automatic smoldvi_link_outs_t smoldvi_link_decode(input smoldvi_link_state_e s);
    smoldvi_link_outs_t o;
    o = '{clk_out_en: 1'b0, lane_rst: 1'b1, timing_rst: 1'b1, link_up: 1'b0};
    case (s)
      SMOLDVI_LINK_CLK_SETTLE,
      SMOLDVI_LINK_CLK_HOLD: begin
        o.clk_out_en = 1'b1;
      end
      SMOLDVI_LINK_RUN: begin
        o.clk_out_en = 1'b1;
        o.lane_rst   = 1'b0;
        o.timing_rst = 1'b0;
        o.link_up    = 1'b1;
      end
      SMOLDVI_LINK_DRAIN: begin
        o.clk_out_en = 1'b1;
        o.lane_rst   = 1'b0;
        o.timing_rst = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Width able to hold (max(a, b) - 1); never narrower than one bit.
  function automatic int smoldvi_cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/smoldvi_hpd_debounce.sv
// smoldvi_hpd_debounce
//   Debounces the raw hot-plug-detect line. hpd_stable takes a new value only
//   after hpd has differed from it for HPD_DEBOUNCE consecutive cycles; any
//   cycle where hpd agrees with hpd_stable restarts the count.
//   hpd is a slow, mechanically driven level; it is sampled directly so the
//   acceptance latency is exactly HPD_DEBOUNCE cycles.
//   Ports:
//     clk_pix    in  pixel clock
//     rst_pix    in  synchronous active-high reset
//     hpd        in  raw hot-plug detect
//     hpd_stable out debounced hot-plug detect, resets to 0
module smoldvi_hpd_debounce
  import smoldvi_pkg::*;
#(
  parameter int HPD_DEBOUNCE = 4096
) (
  input  logic clk_pix,
  input  logic rst_pix,
  input  logic hpd,
  output logic hpd_stable
);

  localparam int CW = smoldvi_cnt_width(HPD_DEBOUNCE, 1);
  localparam logic [CW-1:0] RELOAD = CW'(HPD_DEBOUNCE - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cnt_q      <= RELOAD;
      hpd_stable <= 1'b0;
    end else if (hpd == hpd_stable) begin
      cnt_q <= RELOAD;
    end else if (cnt_q == '0) begin
      hpd_stable <= hpd;
      cnt_q      <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/smoldvi_link_sequencer.sv
// smoldvi_link_sequencer
//   Sequences DVI link bring-up and shutdown in the pixel-clock domain. The
//   clock driver runs alone for CLK_SETTLE_CYCLES before lanes and timing
//   leave reset, and shutdown waits for a frame boundary (bounded by
//   DRAIN_TIMEOUT) so sinks never see a truncated frame.
//   Optional feature: define SMOLDVI_LINK_HPD_EN to add the hpd port and a
//   debouncer (HPD_DEBOUNCE cycles); the link is then enabled by en & hpd.
//   Ports:
//     clk_pix    in  pixel clock
//     rst_pix    in  synchronous active-high reset
//     en         in  level-sensitive link enable
//     pll_locked in  PLL lock, already synchronous to clk_pix
//     hpd        in  raw hot-plug detect (SMOLDVI_LINK_HPD_EN only)
//     frame_end  in  pulse on last pixel of a frame
//     clk_out_en out pixel-clock driver enable
//     lane_rst   out TMDS encoder/serialiser reset
//     timing_rst out timing generator reset
//     link_up    out high only in RUN
//     state      out current state encoding (smoldvi_link_state_e)
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   OFF        | clock gated, everything in reset, waiting for go
//   WAIT_LOCK  | go seen, waiting for PLL lock
//   CLK_SETTLE | clock running, data still in reset
//   RUN        | link active
//   DRAIN      | go dropped, waiting for frame_end or timeout
//   CLK_HOLD   | data back in reset, clock kept running before gating
module smoldvi_link_sequencer
  import smoldvi_pkg::*;
#(
  parameter int CLK_SETTLE_CYCLES = 1024,
  parameter int DRAIN_TIMEOUT     = 1 << 20
`ifdef SMOLDVI_LINK_HPD_EN
  ,
  parameter int HPD_DEBOUNCE      = 4096
`endif
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       en,
  input  logic       pll_locked,
`ifdef SMOLDVI_LINK_HPD_EN
  input  logic       hpd,
`endif
  input  logic       frame_end,
  output logic       clk_out_en,
  output logic       lane_rst,
  output logic       timing_rst,
  output logic       link_up,
  output logic [2:0] state
);

  localparam int CW = smoldvi_cnt_width(CLK_SETTLE_CYCLES, DRAIN_TIMEOUT);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(CLK_SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_TIMEOUT - 1);

  smoldvi_link_state_e state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  smoldvi_link_outs_t  outs_q;
  logic                go;

`ifdef SMOLDVI_LINK_HPD_EN
  logic hpd_stable;

  smoldvi_hpd_debounce #(
    .HPD_DEBOUNCE (HPD_DEBOUNCE)
  ) u_hpd_debounce (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .hpd        (hpd),
    .hpd_stable (hpd_stable)
  );

  assign go = en & hpd_stable;
`else
  assign go = en;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      SMOLDVI_LINK_OFF: begin
        if (go) state_d = SMOLDVI_LINK_WAIT_LOCK;
      end
      SMOLDVI_LINK_WAIT_LOCK: begin
        if (!go) begin
          state_d = SMOLDVI_LINK_OFF;
        end else if (pll_locked) begin
          state_d = SMOLDVI_LINK_CLK_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      SMOLDVI_LINK_CLK_SETTLE: begin
        // Abandoning bring-up still gives the sink a full clock-only tail.
        if (!go) begin
          state_d = SMOLDVI_LINK_CLK_HOLD;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = SMOLDVI_LINK_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SMOLDVI_LINK_RUN: begin
        // frame_end is not looked at here, so a pulse coincident with the
        // move into DRAIN cannot end the drain early.
        if (!go) begin
          state_d = SMOLDVI_LINK_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      SMOLDVI_LINK_DRAIN: begin
        if (frame_end || (cnt_q == '0)) begin
          state_d = SMOLDVI_LINK_CLK_HOLD;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SMOLDVI_LINK_CLK_HOLD: begin
        if (cnt_q == '0) begin
          state_d = SMOLDVI_LINK_OFF;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = SMOLDVI_LINK_OFF;
        cnt_d   = '0;
      end
    endcase

    // Losing lock while the clock driver is enabled beats everything else.
    if (!pll_locked &&
        (state_q inside {SMOLDVI_LINK_CLK_SETTLE, SMOLDVI_LINK_RUN,
                         SMOLDVI_LINK_DRAIN, SMOLDVI_LINK_CLK_HOLD})) begin
      state_d = SMOLDVI_LINK_OFF;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as state with no input-to-output path.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= SMOLDVI_LINK_OFF;
      cnt_q   <= '0;
      outs_q  <= smoldvi_link_decode(SMOLDVI_LINK_OFF);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= smoldvi_link_decode(state_d);
    end
  end

  assign clk_out_en = outs_q.clk_out_en;
  assign lane_rst   = outs_q.lane_rst;
  assign timing_rst = outs_q.timing_rst;
  assign link_up    = outs_q.link_up;
  assign state      = state_q;

endmodule

// File: tb/tb_smoldvi_link_sequencer.sv
module tb_smoldvi_link_sequencer;

  localparam int CS   = 4;
  localparam int DT_A = 32;
  localparam int DT_B = 8;
`ifdef SMOLDVI_LINK_HPD_EN
  localparam int HPD_DB = 16;
`endif

  // {state[2:0], clk_out_en, lane_rst, timing_rst, link_up}
  localparam logic [6:0] O_OFF = {3'd0, 4'b0110};
  localparam logic [6:0] O_WL  = {3'd1, 4'b0110};
  localparam logic [6:0] O_CS  = {3'd2, 4'b1110};
  localparam logic [6:0] O_RUN = {3'd3, 4'b1001};
  localparam logic [6:0] O_DR  = {3'd4, 4'b1000};
  localparam logic [6:0] O_CH  = {3'd5, 4'b1110};

  localparam logic [6:0] BRING [6] = '{O_WL, O_CS, O_CS, O_CS, O_CS, O_RUN};
  localparam logic [6:0] RESTART [6] = '{O_CH, O_CH, O_CH, O_OFF, O_WL, O_CS};

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic en = 1'b0;
  logic pll_locked = 1'b1;
  logic frame_end = 1'b0;
`ifdef SMOLDVI_LINK_HPD_EN
  logic hpd = 1'b0;
`endif

  logic       coe_a, lrst_a, trst_a, up_a;
  logic [2:0] st_a;
  logic       coe_b, lrst_b, trst_b, up_b;
  logic [2:0] st_b;
  logic [6:0] obs_a, obs_b;

  assign obs_a = {st_a, coe_a, lrst_a, trst_a, up_a};
  assign obs_b = {st_b, coe_b, lrst_b, trst_b, up_b};

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  smoldvi_link_sequencer #(
    .CLK_SETTLE_CYCLES (CS),
    .DRAIN_TIMEOUT     (DT_A)
`ifdef SMOLDVI_LINK_HPD_EN
    , .HPD_DEBOUNCE    (HPD_DB)
`endif
  ) dut_a (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .en         (en),
    .pll_locked (pll_locked),
`ifdef SMOLDVI_LINK_HPD_EN
    .hpd        (hpd),
`endif
    .frame_end  (frame_end),
    .clk_out_en (coe_a),
    .lane_rst   (lrst_a),
    .timing_rst (trst_a),
    .link_up    (up_a),
    .state      (st_a)
  );

  smoldvi_link_sequencer #(
    .CLK_SETTLE_CYCLES (CS),
    .DRAIN_TIMEOUT     (DT_B)
`ifdef SMOLDVI_LINK_HPD_EN
    , .HPD_DEBOUNCE    (HPD_DB)
`endif
  ) dut_b (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .en         (en),
    .pll_locked (pll_locked),
`ifdef SMOLDVI_LINK_HPD_EN
    .hpd        (hpd),
`endif
    .frame_end  (frame_end),
    .clk_out_en (coe_b),
    .lane_rst   (lrst_b),
    .timing_rst (trst_b),
    .link_up    (up_b),
    .state      (st_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_pix);
      #1;
    end
  endtask

  // After reset release, give the debouncer time to accept hpd=1.
  task automatic post_reset_settle();
`ifdef SMOLDVI_LINK_HPD_EN
    hpd = 1'b1;
    step(HPD_DB + 1);
`else
    step(1);
`endif
  endtask

  task automatic test_reset();
    rst_pix = 1'b1; en = 1'b0; pll_locked = 1'b1; frame_end = 1'b0;
    step(2);
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL reset_a: got %b want %b", obs_a, O_OFF); end
    checks++; if (obs_b !== O_OFF) begin errors++; $display("FAIL reset_b: got %b want %b", obs_b, O_OFF); end
    rst_pix = 1'b0;
    post_reset_settle();
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL idle_off: got %b want %b", obs_a, O_OFF); end
  endtask

  task automatic test_bringup();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (obs_a !== BRING[i]) begin
        errors++; $display("FAIL bringup edge %0d: got %b want %b", i + 1, obs_a, BRING[i]);
      end
    end
    checks++; if (obs_b !== O_RUN) begin errors++; $display("FAIL bringup_b: got %b want %b", obs_b, O_RUN); end
  endtask

  // dut_a drains until frame_end; dut_b (DRAIN_TIMEOUT=8) times out meanwhile.
  task automatic test_drain_frame_end();
    en = 1'b0;
    step(1);
    checks++; if (obs_a !== O_DR) begin errors++; $display("FAIL drain_entry: got %b want %b", obs_a, O_DR); end
    step(7);
    checks++; if (obs_b !== O_DR) begin errors++; $display("FAIL timeout_d7: got %b want %b", obs_b, O_DR); end
    step(1);
    checks++; if (obs_b !== O_CH) begin errors++; $display("FAIL timeout_d8: got %b want %b", obs_b, O_CH); end
    checks++; if (obs_a !== O_DR) begin errors++; $display("FAIL drain_d8: got %b want %b", obs_a, O_DR); end
    step(1);
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++; if (obs_a !== O_CH) begin errors++; $display("FAIL frame_end_hold: got %b want %b", obs_a, O_CH); end
    step(3);
    checks++; if (obs_a !== O_CH) begin errors++; $display("FAIL hold_tail: got %b want %b", obs_a, O_CH); end
    step(1);
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL clk_gated: got %b want %b", obs_a, O_OFF); end
    checks++; if (obs_b !== O_OFF) begin errors++; $display("FAIL timeout_off: got %b want %b", obs_b, O_OFF); end
  endtask

  task automatic test_pll_loss();
    en = 1'b1;
    step(6);
    checks++; if (obs_a !== O_RUN) begin errors++; $display("FAIL pll_run: got %b want %b", obs_a, O_RUN); end
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL pll_loss_a: got %b want %b", obs_a, O_OFF); end
    checks++; if (obs_b !== O_OFF) begin errors++; $display("FAIL pll_loss_b: got %b want %b", obs_b, O_OFF); end
    step(1);
    checks++; if (obs_a !== O_WL) begin errors++; $display("FAIL pll_reseq_wl: got %b want %b", obs_a, O_WL); end
    step(1);
    checks++; if (obs_a !== O_CS) begin errors++; $display("FAIL pll_reseq_cs: got %b want %b", obs_a, O_CS); end
    step(4);
    checks++; if (obs_a !== O_RUN) begin errors++; $display("FAIL pll_reseq_run: got %b want %b", obs_a, O_RUN); end
  endtask

  task automatic test_drain_reenable();
    en = 1'b0;
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++; if (obs_a !== O_DR) begin errors++; $display("FAIL coincident_fe: got %b want %b", obs_a, O_DR); end
    step(1);
    en = 1'b1;
    step(3);
    checks++; if (obs_a !== O_DR) begin errors++; $display("FAIL reenable_drain: got %b want %b", obs_a, O_DR); end
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
    checks++; if (obs_a !== O_CH) begin errors++; $display("FAIL reenable_hold: got %b want %b", obs_a, O_CH); end
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (obs_a !== RESTART[i]) begin
        errors++; $display("FAIL restart step %0d: got %b want %b", i, obs_a, RESTART[i]);
      end
    end
    checks++; if (obs_b !== O_CS) begin errors++; $display("FAIL restart_b: got %b want %b", obs_b, O_CS); end
  endtask

  task automatic test_mid_reset();
    rst_pix = 1'b1;
    step(1);
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL mid_reset_a: got %b want %b", obs_a, O_OFF); end
    checks++; if (obs_b !== O_OFF) begin errors++; $display("FAIL mid_reset_b: got %b want %b", obs_b, O_OFF); end
    rst_pix = 1'b0;
    en = 1'b0;
    post_reset_settle();
  endtask

`ifdef SMOLDVI_LINK_HPD_EN
  task automatic test_hpd();
    rst_pix = 1'b1; hpd = 1'b0; en = 1'b1; pll_locked = 1'b1;
    step(1);
    rst_pix = 1'b0;
    step(2);
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL hpd_low_off: got %b want %b", obs_a, O_OFF); end
    hpd = 1'b1;
    step(15);
    hpd = 1'b0;
    step(3);
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL hpd_glitch: got %b want %b", obs_a, O_OFF); end
    hpd = 1'b1;
    step(16);
    checks++; if (obs_a !== O_OFF) begin errors++; $display("FAIL hpd_accept_edge: got %b want %b", obs_a, O_OFF); end
    step(1);
    checks++; if (obs_a !== O_WL) begin errors++; $display("FAIL hpd_wait_lock: got %b want %b", obs_a, O_WL); end
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_drain_frame_end();
    test_pll_loss();
    test_drain_reenable();
    test_mid_reset();
`ifdef SMOLDVI_LINK_HPD_EN
    test_hpd();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
